// File: rtl/twiddle_seq.sv
//------------------------------------------------------------------------------
// Module   : twiddle_seq
// Purpose  : Address sequencer for the twiddle ROM of a mixed-radix FFT/DFT
//            stage. For N = P x Q, it emits (stride*p*q) mod N with p as the
//            outer index and q as the inner index. The pattern repeats for
//            num_blk blocks, with ready/valid backpressure. tw_vld is aligned
//            with the ROM read latency TW_LAT (0 or 1).
// Options  : define TWSEQ_INVERSE_EN to add the inv port. When inv is set,
//            the sequencer emits conjugate addresses (N - acc) mod N.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module twiddle_seq #(
   parameter int N      = 24,
   parameter int P      = 4,
   parameter int Q      = 6,
   parameter int AW     = 11,
   parameter int TW_LAT = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] stride,
   input  logic [7:0]    num_blk,
   input  logic          out_ready,
`ifdef TWSEQ_INVERSE_EN
   input  logic          inv,
`endif
   output logic [AW-1:0] addr,
   output logic          addr_vld,
   output logic          last,
   output logic          tw_vld,
   output logic          busy,
   output logic          done
);

   // Counter widths. These are kept at least one bit wide so that
   // degenerate shapes with P = 1 or Q = 1 still elaborate.
   localparam int PW = (P > 1) ? $clog2(P) : 1;
   localparam int QW = (Q > 1) ? $clog2(Q) : 1;

   localparam logic [PW-1:0] P_LAST = PW'(P - 1);
   localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);
   localparam logic [AW:0]   N_EXT  = (AW + 1)'(N);
   localparam logic [AW-1:0] N_AW   = AW'(N);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Modular add for two operands that are both already below N.
   // A single conditional subtract is enough, so no divider or
   // multiplier is needed.
   function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                             input logic [AW-1:0] b);
      logic [AW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end
      return sum[AW-1:0];
   endfunction

   logic [1:0]    state_q,  state_d;
   logic [AW-1:0] stride_q, stride_d;
   logic [7:0]    nblk_q,   nblk_d;
   logic [PW-1:0] p_q,      p_d;
   logic [QW-1:0] q_q,      q_d;
   logic [7:0]    blk_q,    blk_d;
   logic [AW-1:0] rs_q,     rs_d;     // row step = stride*p mod N
   logic [AW-1:0] acc_q,    acc_d;    // running address = rs*q mod N
`ifdef TWSEQ_INVERSE_EN
   logic          inv_q,    inv_d;
`endif

   logic          w_xfer;
   logic          w_last;
   logic [AW-1:0] w_addr_run;
   logic [AW-1:0] w_acc_next;
   logic [AW-1:0] w_rs_next;

   assign w_xfer     = (state_q == S_RUN) && out_ready;
   assign w_last     = (p_q == P_LAST) && (q_q == Q_LAST) &&
                       (blk_q == (nblk_q - 8'd1));
   assign w_acc_next = mod_add(acc_q, rs_q);
   assign w_rs_next  = mod_add(rs_q, stride_q);

`ifdef TWSEQ_INVERSE_EN
   // Conjugate twiddle: (N - acc) mod N. acc = 0 stays 0.
   assign w_addr_run = (inv_q && (acc_q != '0)) ? (N_AW - acc_q) : acc_q;
`else
   assign w_addr_run = acc_q;
`endif

   // FSM state register; reset aborts any run without a done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start only counts in IDLE, DONE always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)            state_d = S_RUN;
         S_RUN:   if (w_xfer && w_last) state_d = S_DONE;
         S_DONE:                        state_d = S_IDLE;
         default:                       state_d = S_IDLE;
      endcase
   end

   // FSM outputs: address and flags are only driven while running
   always_comb begin
      addr     = '0;
      addr_vld = 1'b0;
      last     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         S_RUN: begin
            addr     = w_addr_run;
            addr_vld = 1'b1;
            last     = w_last;
            busy     = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next state: latch config at start, step the counters on transfers
   always_comb begin
      stride_d = stride_q;
      nblk_d   = nblk_q;
      p_d      = p_q;
      q_d      = q_q;
      blk_d    = blk_q;
      rs_d     = rs_q;
      acc_d    = acc_q;
`ifdef TWSEQ_INVERSE_EN
      inv_d    = inv_q;
`endif
      if ((state_q == S_IDLE) && start) begin
         stride_d = stride;
         nblk_d   = (num_blk == 8'd0) ? 8'd1 : num_blk;
`ifdef TWSEQ_INVERSE_EN
         inv_d    = inv;
`endif
         p_d      = '0;
         q_d      = '0;
         blk_d    = '0;
         rs_d     = '0;
         acc_d    = '0;
      end else if (w_xfer) begin
         if (q_q != Q_LAST) begin
            q_d   = q_q + QW'(1);
            acc_d = w_acc_next;
         end else begin
            q_d   = '0;
            acc_d = '0;
            if (p_q != P_LAST) begin
               p_d  = p_q + PW'(1);
               rs_d = w_rs_next;
            end else begin
               p_d   = '0;
               rs_d  = '0;
               blk_d = blk_q + 8'd1;
            end
         end
      end
   end

   // Datapath registers; everything holds during a stall (no transfer)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stride_q <= '0;
         nblk_q   <= '0;
         p_q      <= '0;
         q_q      <= '0;
         blk_q    <= '0;
         rs_q     <= '0;
         acc_q    <= '0;
`ifdef TWSEQ_INVERSE_EN
         inv_q    <= 1'b0;
`endif
      end else begin
         stride_q <= stride_d;
         nblk_q   <= nblk_d;
         p_q      <= p_d;
         q_q      <= q_d;
         blk_q    <= blk_d;
         rs_q     <= rs_d;
         acc_q    <= acc_d;
`ifdef TWSEQ_INVERSE_EN
         inv_q    <= inv_d;
`endif
      end
   end

   // tw_vld follows accepted addresses, delayed to match ROM read latency
   generate
      if (TW_LAT == 0) begin : g_lat0
         assign tw_vld = w_xfer;
      end else begin : g_lat1
         logic tw_vld_q;
         // One-cycle copy of the transfer strobe for a registered ROM output
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               tw_vld_q <= 1'b0;
            end else begin
               tw_vld_q <= w_xfer;
            end
         end
         assign tw_vld = tw_vld_q;
      end
   endgenerate

endmodule

`default_nettype wire

// File: doc/twiddle_seq.md
Name: twiddle_seq

Overview:
- Sequencer that drives the address port of the 24-entry twiddle ROM for mixed-radix FFT/DFT stages.
- For an N = P×Q decomposition, emits twiddle indices (stride·p·q) mod N row by row: p = 0..P-1 outer, q = 0..Q-1 inner.
- Repeats that pattern for a configured number of blocks, with ready/valid backpressure.
- Provides a valid flag delayed to align with ROM output data, whether the ROM has its output register or not.

Parameters:
- N, 24, twiddle table size; all emitted addresses are < N.
- P, 4, rows (outer index count); P*Q must equal N.
- Q, 6, columns (inner index count).
- AW, 11, address width; matches the ROM addr port.
- TW_LAT, 0, ROM read latency in cycles (0 or 1); set to 1 when the ROM output register is enabled.

Ports:
- clk, in, 1, master clock, rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle request to begin a run; honoured only in IDLE.
- stride, in, AW, twiddle stride, sampled at start; must be < N.
- num_blk, in, 8, blocks per run, sampled at start; 0 is treated as 1.
- out_ready, in, 1, consumer accepts the current address.
- addr, out, AW, twiddle ROM address.
- addr_vld, out, 1, addr is valid this cycle.
- last, out, 1, addr is the final address of the run.
- tw_vld, out, 1, addr_vld delayed by TW_LAT cycles; qualifies ROM data.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse after the last transfer.
- inv, in, 1, inverse transform select (present only with TWSEQ_INVERSE_EN).

Behaviour:
- Reset state: IDLE. addr=0, addr_vld=0, last=0, tw_vld=0, busy=0, done=0. All counters and accumulators clear.
- Reset mid-run aborts immediately; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE→RUN on start:
  - latch stride, num_blk (0→1), and inv;
  - clear p, q, blk counters, row step rs, and accumulator acc.
- RUN:
  - addr_vld=1 and busy=1.
  - addr = acc in forward mode.
  - A transfer occurs when addr_vld && out_ready.
- On each transfer:
  - If q<Q-1: q++, acc = (acc+rs) mod N.
  - Else q=0, acc=0, and:
    - if p<P-1: p++, rs = (rs+stride) mod N;
    - else p=0, rs=0, blk++.
- Modular add: compute sum = a+b at AW+1 bits; subtract N if sum ≥ N. Both operands are < N. No multiplier.
- Stall: when out_ready=0, addr, last and all counters hold. The ROM output is therefore stable during the stall.
- last=1 when p=P-1, q=Q-1, and blk=num_blk-1.
- A transfer with last=1 moves the FSM to DONE.
- DONE lasts one cycle: done=1, addr_vld=0, busy=0, then the FSM returns to IDLE.
- start in RUN or DONE is ignored.
- start in the same cycle as the DONE→IDLE transition is ignored; a new start must come in IDLE.
- Throughput: one address per cycle while out_ready=1. The first address appears the cycle after start is sampled.
- tw_vld:
  - TW_LAT=0: equals addr_vld && out_ready.
  - TW_LAT=1: registered copy of addr_vld && out_ready; cleared by rst.
- addr returns to 0 when not in RUN.

Optional Feature:
- Macro: TWSEQ_INVERSE_EN.
- Defined: port inv exists and is sampled at start. When the latched inv=1, addr = (N-acc) mod N, i.e. conjugate twiddles (acc=0 gives 0). Counters and timing are unchanged.
- Undefined: no inv port; forward addresses only.

Test Plan:
- Forward, N=24/P=4/Q=6, stride=1, num_blk=1, out_ready=1 → 24 addresses:
  - rows 0,0,0,0,0,0 / 0,1,2,3,4,5 / 0,2,4,6,8,10 / 0,3,6,9,12,15;
  - last high with addr=15; done pulses the next cycle, then IDLE.
- Wrap: P=3/Q=8, stride=5 → row p=3 is not reached; row p=2 has step 10: 0,10,20,6,16,2,12,22. All addresses < 24.
- Backpressure: out_ready low for 3 cycles while addr=3 in row 1 → addr holds 3 and tw_vld stays 0. Sequence resumes with 4; no address is skipped or duplicated.
- Repeats and latency: num_blk=2, TW_LAT=1 → 48 transfers, last only on the 48th. tw_vld lags addr_vld by exactly 1 cycle. num_blk=0 behaves as 1.
- Control hazards:
  - start pulsed during RUN → ignored; the sequence is unaffected.
  - rst asserted at transfer 10 → all outputs 0 asynchronously, no done pulse.
  - A new start after rst → restarts from addr 0.
- With TWSEQ_INVERSE_EN, inv=1, stride=1 → row 1 is 0,23,22,21,20,19; row 3 is 0,21,18,15,12,9.
